// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and constants for the multi-cycle ALU (alu_seq).
//             Optional divider selected by macro ALU_SEQ_UDIV_EN.
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // ALU operation encoding as driven by the controller.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_ORR  = 3'b011,
        ALU_EOR  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_UDIV = 3'b110,
        ALU_RSVD = 3'b111
    } aluop_t;

    // Sequencer state, explicitly encoded.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // True for operations that run on the iterative datapath.
    function automatic logic is_iter_op(input aluop_t op);
`ifdef ALU_SEQ_UDIV_EN
        return (op == ALU_MUL) || (op == ALU_UDIV);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_if
//  Purpose  : Controller <-> ALU handshake and operand/result bus.
//             master = controller side, slave = ALU side.
//  Revision : 1.0  initial release
// ============================================================================
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic             ready;
    aluop_t           ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic [3:0]       ALUFlags;
    logic             done;

    modport master (
        output start, ALUControl, SrcA, SrcB,
        input  ready, ALUResult, ALUFlags, done
    );

    modport slave (
        input  start, ALUControl, SrcA, SrcB,
        output ready, ALUResult, ALUFlags, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_iter_core
//  Purpose  : Iterative datapath: shift-add multiplier and, when macro
//             ALU_SEQ_UDIV_EN is defined, a restoring divider. One step per
//             clock after load; 'result' shows the value after the step
//             being taken this cycle, so the final value is available
//             combinationally in the last step cycle.
//  Revision : 1.0  initial release
// ============================================================================
module alu_iter_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  aluop_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    aluop_t           r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_mul_next;

    // Partial product after consuming the current multiplier LSB.
    assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Multiplier registers: load operands, then shift one bit per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= ALU_ADD;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (load) begin
            r_op     <= op;
            r_acc    <= '0;
            r_mcand  <= a;
            r_mplier <= b;
        end else begin
            r_acc    <= w_mul_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

`ifdef ALU_SEQ_UDIV_EN
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvs;
    logic             r_dz;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;

    // Bring down the next dividend bit and trial-subtract the divisor;
    // a zero divisor always "fits", giving an all-ones quotient.
    assign w_shift     = {r_rem, r_quot[WIDTH-1]};
    assign w_diff      = w_shift - {1'b0, r_dvs};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_rem_next  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quot_next = {r_quot[WIDTH-2:0], w_ge};

    // Divider registers: quotient register starts as the dividend.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_dvs  <= '0;
            r_dz   <= 1'b0;
        end else if (load) begin
            r_rem  <= '0;
            r_quot <= a;
            r_dvs  <= b;
            r_dz   <= (op == ALU_UDIV) && (b == '0);
        end else begin
            r_rem  <= w_rem_next;
            r_quot <= w_quot_next;
        end
    end

    assign result = (r_op == ALU_UDIV) ? w_quot_next : w_mul_next;
    assign dz     = r_dz;
`else
    assign result = (r_op == ALU_MUL) ? w_mul_next : '0;
    assign dz     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Multi-cycle ALU for the multicycle ARM core. Single-cycle
//             ADD/SUB/AND/ORR/EOR, iterative MUL and optional UDIV
//             (enabled by macro ALU_SEQ_UDIV_EN). Registered result and
//             {N,Z,C,V} flags with a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam int                 c_msb      = WIDTH - 1;

    alu_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_done;
    logic               r_ready;

    logic               w_accept;
    logic               w_iter_op;
    logic               w_sub;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sc_result;
    logic               w_sc_c;
    logic               w_sc_v;
    logic [3:0]         w_sc_flags;
    logic [WIDTH-1:0]   w_iter_result;
    logic               w_iter_dz;
    logic [3:0]         w_iter_flags;

    // Assemble {N,Z,C,V}; N and Z always come from the result.
    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = res[c_msb];
        f[FLAG_Z] = (res == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    assign w_accept  = bus.start && r_ready;
    assign w_iter_op = is_iter_op(bus.ALUControl);

    // Shared adder; subtraction is A + ~B + 1.
    assign w_sub   = (bus.ALUControl == ALU_SUB);
    assign w_b_eff = w_sub ? ~bus.SrcB : bus.SrcB;
    assign w_sum   = {1'b0, bus.SrcA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_sub};

    // Single-cycle result and carry/overflow; reserved (and UDIV when the
    // divider is not built) fall through to a zero result.
    always_comb begin
        w_sc_result = '0;
        w_sc_c      = 1'b0;
        w_sc_v      = 1'b0;
        case (bus.ALUControl)
            ALU_ADD, ALU_SUB: begin
                w_sc_result = w_sum[WIDTH-1:0];
                w_sc_c      = w_sum[WIDTH];
                w_sc_v      = ~(bus.SrcA[c_msb] ^ bus.SrcB[c_msb] ^ w_sub)
                              & (bus.SrcA[c_msb] ^ w_sum[c_msb]);
            end
            ALU_AND: w_sc_result = bus.SrcA & bus.SrcB;
            ALU_ORR: w_sc_result = bus.SrcA | bus.SrcB;
            ALU_EOR: w_sc_result = bus.SrcA ^ bus.SrcB;
            default: w_sc_result = '0;
        endcase
    end

    assign w_sc_flags   = make_flags(w_sc_result, w_sc_c, w_sc_v);
    assign w_iter_flags = make_flags(w_iter_result, 1'b0, w_iter_dz);

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (w_accept && w_iter_op),
        .op     (bus.ALUControl),
        .a      (bus.SrcA),
        .b      (bus.SrcB),
        .result (w_iter_result),
        .dz     (w_iter_dz)
    );

    // Sequencer: accept in IDLE/DONE, count BUSY cycles, latch outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_BUSY: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state  <= S_DONE;
                        r_cnt    <= '0;
                        r_result <= w_iter_result;
                        r_flags  <= w_iter_flags;
                        r_done   <= 1'b1;
                        r_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        if (w_iter_op) begin
                            r_state <= S_BUSY;
                            r_cnt   <= '0;
                            r_ready <= 1'b0;
                        end else begin
                            r_state  <= S_DONE;
                            r_result <= w_sc_result;
                            r_flags  <= w_sc_flags;
                            r_done   <= 1'b1;
                            r_ready  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.ALUResult = r_result;
    assign bus.ALUFlags  = r_flags;
    assign bus.done      = r_done;
    assign bus.ready     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Self-checking bench for alu_seq (WIDTH=32). Honors macro
//             ALU_SEQ_UDIV_EN in its reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on 32-bit values.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        logic c;
        logic v;
        c   = 1'b0;
        v   = 1'b0;
        r   = '0;
        lat = 1;
        case (op)
            3'd0: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r   = a * b;
                lat = 33;
            end
            3'd6: begin
`ifdef ALU_SEQ_UDIV_EN
                lat = 33;
                if (b == 0) begin
                    r = 32'hFFFF_FFFF;
                    v = 1'b1;
                end else begin
                    r = a / b;
                end
`else
                r = '0;
`endif
            end
            default: r = '0;
        endcase
        f = {r[31], (r == 0), c, v};
    endfunction

    // Issue one operation (caller is at a safe drive point), scramble the
    // inputs after accept, poke start during BUSY, then check the outcome.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic [3:0]  ef;
        int          elat;
        int          lat;
        int          k;
        model(op, a, b, er, ef, elat);
        k = 0;
        while (!bus.ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_ready_before"}, {31'b0, bus.ready}, 32'd1);
        bus.start      = 1'b1;
        bus.ALUControl = aluop_t'(op);
        bus.SrcA       = a;
        bus.SrcB       = b;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.SrcA       = $urandom;
        bus.SrcB       = $urandom;
        bus.ALUControl = aluop_t'(3'($urandom));
        lat = 1;
        while (!bus.done && lat < 100) begin
            check({tag, "_busy_ready"}, {31'b0, bus.ready}, 32'd0);
            bus.start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            bus.start = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_result"}, bus.ALUResult, er);
        check({tag, "_flags"}, {28'b0, bus.ALUFlags}, {28'b0, ef});
        check({tag, "_ready_done"}, {31'b0, bus.ready}, 32'd1);
    endtask

    initial begin
        int n_done;
        n_cmp          = 0;
        n_err          = 0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.ALUControl = ALU_ADD;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", bus.ALUResult, 32'h0);
        check("rst_flags", {28'b0, bus.ALUFlags}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_ready", {31'b0, bus.ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Directed cases
        do_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        do_op("sub_eq", 3'd1, 32'h5, 32'h5);
        do_op("sub_neg", 3'd1, 32'h3, 32'h5);
        do_op("mul_wrap", 3'd5, 32'h0001_0000, 32'h0001_0000);
        do_op("mul_small", 3'd5, 32'd7, 32'd6);
        do_op("udiv", 3'd6, 32'd100, 32'd7);
        do_op("udiv_dz", 3'd6, 32'd5, 32'd0);
        do_op("rsvd", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        // Back-to-back: the next call accepts in the DONE cycle.
        do_op("b2b_first", 3'd3, 32'h00F0, 32'h0F00);
        do_op("b2b_and", 3'd2, 32'hF0F0, 32'hFF00);

        // Reset during MUL BUSY cycle 10
        bus.start      = 1'b1;
        bus.ALUControl = ALU_MUL;
        bus.SrcA       = 32'd123;
        bus.SrcB       = 32'd456;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_result", bus.ALUResult, 32'h0);
        check("abort_flags", {28'b0, bus.ALUFlags}, 32'h0);
        check("abort_ready", {31'b0, bus.ready}, 32'd1);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
